// File: rtl/daccess_bridge_pkg.sv
// Shared types and constants for the core data-access bridge.
package daccess_bridge_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StRsp  = 2'd2,
        StDone = 2'd3
    } da_state_e;

    localparam logic [3:0] DA_REN_WORD = 4'hF;

    // A limit of 0 still needs a legal 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit == 0) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/daccess_timeout.sv
// Clearable saturating cycle counter; flags expiry at LIMIT-1 (LIMIT=0 never expires).
module daccess_timeout
    import daccess_bridge_pkg::*;
#(
    parameter int unsigned LIMIT = 256
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expire
);

    localparam int unsigned CntW    = cnt_width(LIMIT);
    localparam int unsigned LastVal = (LIMIT == 0) ? 0 : LIMIT - 1;

    logic [CntW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CntW{1'b1}})) begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end

    assign o_expire = (LIMIT != 0) && (r_cnt == CntW'(LastVal));

endmodule

// File: rtl/daccess_bridge.sv
// Bridges the core's daccess port onto a req/gnt/rsp bus, one access at a time,
// with a timeout guard that completes the access if the slave never answers.
module daccess_bridge
    import daccess_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
    input  logic        cpu_clk,
    input  logic        cpu_rstn,
    input  logic [3:0]  da_ren,
    input  logic [31:0] da_addr,
    input  logic [3:0]  da_wen,
    input  logic [31:0] da_wdata,
    output logic        da_valid,
    output logic [31:0] da_rdata,
    output logic        da_wresp,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rsp,
    input  logic [31:0] bus_rdata,
    output logic        err_timeout,
    input  logic        err_clr
);

    da_state_e   r_state, w_state_d;
    logic        r_req_lvl_d;
    logic        r_we, w_we_d;
    logic        r_bus_req, w_bus_req_d;
    logic [31:0] r_bus_addr, w_bus_addr_d;
    logic [3:0]  r_bus_wstrb, w_bus_wstrb_d;
    logic [31:0] r_bus_wdata, w_bus_wdata_d;
    logic        r_da_valid, w_da_valid_d;
    logic        r_da_wresp, w_da_wresp_d;
    logic [31:0] r_da_rdata, w_da_rdata_d;
    logic        r_err_timeout, w_err_d;
    logic        w_req_lvl, w_req_edge, w_expire, w_timeout_hit;
    logic        w_cnt_clr, w_cnt_inc;
    logic        w_unused_addr;

    assign w_req_lvl     = (|da_ren) | (|da_wen);
    assign w_req_edge    = w_req_lvl & ~r_req_lvl_d;
    assign w_unused_addr = ^da_addr[1:0];

    assign w_cnt_clr = (r_state == StIdle);
    assign w_cnt_inc = (r_state == StReq) || (r_state == StRsp);

    daccess_timeout #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk   (cpu_clk),
        .i_rstn  (cpu_rstn),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_cnt_inc),
        .o_expire(w_expire)
    );

    always_comb begin
        w_state_d     = r_state;
        w_we_d        = r_we;
        w_bus_addr_d  = r_bus_addr;
        w_bus_wstrb_d = r_bus_wstrb;
        w_bus_wdata_d = r_bus_wdata;
        w_bus_req_d   = 1'b0;
        w_da_valid_d  = 1'b0;
        w_da_wresp_d  = 1'b0;
        w_da_rdata_d  = '0;
        w_timeout_hit = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_req_edge) begin
                    w_state_d     = StReq;
                    w_we_d        = |da_wen;
                    w_bus_addr_d  = {da_addr[31:2], 2'b00};
                    w_bus_wstrb_d = da_wen;
                    w_bus_wdata_d = da_wdata;
                    w_bus_req_d   = 1'b1;
                end
            end
            StReq, StRsp: begin
                // A response always beats an expiring counter in the same cycle.
                if (bus_rsp && (bus_gnt || (r_state == StRsp))) begin
                    w_state_d    = StDone;
                    w_da_valid_d = ~r_we;
                    w_da_wresp_d = r_we;
                    w_da_rdata_d = r_we ? 32'd0 : bus_rdata;
                end else if (w_expire) begin
                    w_state_d     = StDone;
                    w_timeout_hit = 1'b1;
                    w_da_valid_d  = ~r_we;
                    w_da_wresp_d  = r_we;
                    w_da_rdata_d  = r_we ? 32'd0 : TIMEOUT_RDATA;
                end else if (r_state == StReq) begin
                    if (bus_gnt) begin
                        w_state_d = StRsp;
                    end else begin
                        w_bus_req_d = 1'b1;
                    end
                end
            end
            StDone: w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase

        w_err_d = w_timeout_hit | (r_err_timeout & ~err_clr);
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            r_state       <= StIdle;
            r_req_lvl_d   <= 1'b0;
            r_we          <= 1'b0;
            r_bus_req     <= 1'b0;
            r_bus_addr    <= '0;
            r_bus_wstrb   <= '0;
            r_bus_wdata   <= '0;
            r_da_valid    <= 1'b0;
            r_da_wresp    <= 1'b0;
            r_da_rdata    <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_req_lvl_d   <= w_req_lvl;
            r_we          <= w_we_d;
            r_bus_req     <= w_bus_req_d;
            r_bus_addr    <= w_bus_addr_d;
            r_bus_wstrb   <= w_bus_wstrb_d;
            r_bus_wdata   <= w_bus_wdata_d;
            r_da_valid    <= w_da_valid_d;
            r_da_wresp    <= w_da_wresp_d;
            r_da_rdata    <= w_da_rdata_d;
            r_err_timeout <= w_err_d;
        end
    end

    assign da_valid    = r_da_valid;
    assign da_wresp    = r_da_wresp;
    assign da_rdata    = r_da_rdata;
    assign bus_req     = r_bus_req;
    assign bus_we      = r_we;
    assign bus_addr    = r_bus_addr;
    assign bus_wstrb   = r_bus_wstrb;
    assign bus_wdata   = r_bus_wdata;
    assign err_timeout = r_err_timeout;

endmodule

// File: doc/daccess_bridge.md
Name: daccess_bridge

Overview:
- Sits directly downstream of the CPU core's data access port (daccess_*). Consumes one load/store request at a time.
- Issues the request on a simple req/gnt/rsp data bus toward data RAM and MMIO.
- Returns a one-cycle read-valid or write-response pulse to the core, with a timeout guard so a dead slave cannot hang the pipeline's ldst_suspend.

Parameters:
- TIMEOUT_CYCLES, 256: max cycles from accept to bus response; 0 disables the timeout.
- TIMEOUT_RDATA, 32'hDEAD_BEEF: read data returned on a timed-out load.

Ports:
- cpu_clk  in  1  clock
- cpu_rstn  in  1  reset
- da_ren  in  4  read request, 4'hF when a load is issued
- da_addr  in  32  byte address
- da_wen  in  4  byte write strobes, nonzero for a store
- da_wdata  in  32  store data, already lane-aligned by the core
- da_valid  out  1  one-cycle pulse: da_rdata valid
- da_rdata  out  32  raw read word; the core does extension
- da_wresp  out  1  one-cycle pulse: store complete
- bus_req  out  1  bus request, held until bus_gnt
- bus_we  out  1  1 = write
- bus_addr  out  32  word address, {da_addr[31:2],2'b00}
- bus_wstrb  out  4  byte strobes; 0 for reads
- bus_wdata  out  32  write data
- bus_gnt  in  1  slave accepted the request this cycle
- bus_rsp  in  1  slave response; bus_rdata valid for reads
- bus_rdata  in  32  read data
- err_timeout  out  1  sticky: a timeout occurred
- err_clr  in  1  synchronous clear of err_timeout

Behaviour:
- Reset is cpu_rstn, asynchronous, active-low; clock is cpu_clk.
- Reset values: state=IDLE; all outputs 0; captured registers 0; timeout counter 0.
- Request detect: req_lvl = (|da_ren) | (|da_wen). A new request is a rising edge of req_lvl, using a registered req_lvl_d.
  - A level held across cycles is one request.
  - A second edge while not IDLE is ignored (core contract forbids it).
- If da_wen!=0 and da_ren!=0 together, the access is a write (wen has priority).
- FSM has four states: IDLE, REQ, RSP, DONE.
- IDLE:
  - On a request edge, capture we=|da_wen, addr, wstrb (0 if read), wdata.
  - Go to REQ; counter cleared.
- REQ:
  - bus_req=1 with the captured fields, registered outputs stable until grant.
  - bus_gnt=1: drop bus_req next cycle, go to RSP.
  - If bus_gnt and bus_rsp arrive in the same cycle, go straight to DONE, capturing bus_rdata.
- RSP:
  - Wait for bus_rsp. On bus_rsp, capture bus_rdata for reads and go to DONE.
- DONE (one cycle):
  - Read: da_valid=1 with da_rdata = captured data. Write: da_wresp=1 with da_rdata = 0.
  - Next state IDLE.
- Minimum latency: edge sampled at clock edge N; bus_req high in cycle N+1; gnt+rsp in N+1 gives da_valid/da_wresp high in cycle N+2.
- da_valid/da_wresp are registered. Never both high. Never high outside DONE.
- Timeout:
  - The counter increments each cycle in REQ or RSP.
  - When it reaches TIMEOUT_CYCLES-1 without a response, go to DONE with rdata=TIMEOUT_RDATA (reads), set err_timeout, drop bus_req.
  - A late bus_rsp/bus_gnt arriving in IDLE is discarded.
- err_timeout: set has priority over err_clr in the same cycle.
- Counter width is $clog2(TIMEOUT_CYCLES+1). It saturates rather than wraps.
- Reset mid-transaction: immediate return to IDLE, bus_req drops asynchronously, no response pulse is generated.

Decomposition:
- Shared package: state encoding (IDLE/REQ/RSP/DONE, 2-bit), DA_REN_WORD=4'hF.
- Optional sub-module: daccess_timeout (loadable saturating counter with expire flag).

Test Plan:
- Read, zero-wait slave: da_ren=4'hF, addr=0x1000_0006, slave gnt+rsp in the first REQ cycle with rdata=0x1234_5678 -> bus_addr=0x1000_0004, bus_wstrb=0, da_valid pulses once 2 cycles after the edge with da_rdata=0x1234_5678.
- Store with wait states: da_wen=4'b0011, wdata=0x0000_ABCD, gnt after 3 cycles, rsp 2 cycles later -> bus_req held exactly 4 cycles with stable fields, bus_we=1, bus_wstrb=4'b0011, single da_wresp pulse, da_valid stays 0.
- Held request level: da_ren=4'hF held for 10 cycles -> exactly one bus transaction and one da_valid.
- Timeout: TIMEOUT_CYCLES=8, slave never responds -> da_valid after 8 counted cycles, da_rdata=0xDEAD_BEEF, err_timeout=1. A later bus_rsp is ignored. Pulsing err_clr clears the flag.
- Simultaneous ren=4'hF and wen=4'b1111 -> treated as write: bus_we=1, da_wresp pulses.
- Reset during RSP -> all outputs 0 the same cycle. A subsequent read completes normally.
